// File: rtl/xbar_rr_arbiter.sv
// xbar_rr_arbiter: per-output round-robin arbiter for the 5-port (N,S,E,W,L)
// router crossbar. Produces per-input pop requests and a grant matrix with
// zero latency, keeps one registered priority pointer per output, and counts
// flits discarded for illegal route addresses (saturating).
// Optional wormhole packet locking is compiled in with `XBAR_ARB_PKT_LOCK_EN.
module xbar_rr_arbiter #(
    parameter int NPORT = 5,
    parameter int AW    = 3,
    parameter int CW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       empty_i,
    input  logic [NPORT*AW-1:0]    address_route_i,
    input  logic [NPORT-1:0]       ready_i,
    input  logic [NPORT-1:0]       tail_i,
    output logic [NPORT-1:0]       pop_req_o,
    output logic [NPORT*NPORT-1:0] grant_o,
    output logic [CW-1:0]          drop_cnt_o
);

    localparam int PW = 3;

    logic [PW-1:0]    ptr_q   [NPORT];
    logic [NPORT-1:0] req     [NPORT];   // req[o][i]
    logic [NPORT-1:0] elig    [NPORT];   // requests surviving the lock mask
    logic [NPORT-1:0] gnt     [NPORT];   // gnt[o][i]
    logic [NPORT-1:0] illegal;
    logic [CW-1:0]    drop_cnt_q;
    logic [CW:0]      drop_sum;
    logic [2:0]       drop_add;

    // Decode each head flit into one request per output, or an illegal drop.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            illegal[i] = !empty_i[i] && (address_route_i[AW*i +: AW] >= AW'(NPORT));
        end
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                req[o][i] = !empty_i[i] && (address_route_i[AW*i +: AW] == AW'(o))
                            && ready_i[o];
            end
        end
    end

`ifdef XBAR_ARB_PKT_LOCK_EN
    logic [NPORT-1:0] lock_q;
    logic [PW-1:0]    owner_q [NPORT];

    // While an output is locked, only the packet owner may compete for it.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            elig[o] = lock_q[o] ? (req[o] & (NPORT'(1) << owner_q[o])) : req[o];
        end
    end

    // Lock follows the tail bit of each granted flit: a non-tail flit holds
    // (or takes) the output, the tail flit releases it. No grant, no change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
            for (int o = 0; o < NPORT; o++) owner_q[o] <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                for (int i = 0; i < NPORT; i++) begin
                    if (gnt[o][i]) begin
                        lock_q[o]  <= !tail_i[i];
                        owner_q[o] <= PW'(i);
                    end
                end
            end
        end
    end
`else
    // Every flit is arbitrated independently; the tail flags are not needed.
    logic unused_tail;
    assign unused_tail = ^tail_i;

    // Without locking every request is eligible.
    always_comb begin
        for (int o = 0; o < NPORT; o++) elig[o] = req[o];
    end
`endif

    // Round-robin scan per output, starting at the pointer; first hit wins.
    always_comb begin
        int  start;
        int  idx;
        logic found;
        for (int o = 0; o < NPORT; o++) begin
            gnt[o] = '0;
            found  = 1'b0;
            // Out-of-range pointer values are treated as input 0.
            start  = (ptr_q[o] < PW'(NPORT)) ? int'(ptr_q[o]) : 0;
            for (int k = 0; k < NPORT; k++) begin
                idx = (start + k) % NPORT;
                if (!found && elig[o][idx]) begin
                    gnt[o][idx] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    // Drive the grant matrix and pops; both are forced low while in reset.
    always_comb begin
        grant_o   = '0;
        pop_req_o = '0;
        // NOTE: combinational outputs are gated by rst directly so they drop
        // the instant reset asserts, not at the next clock edge.
        if (!rst) begin
            for (int o = 0; o < NPORT; o++) begin
                grant_o[NPORT*o +: NPORT] = gnt[o];
                pop_req_o                 = pop_req_o | gnt[o];
            end
            pop_req_o = pop_req_o | illegal;
        end
    end

    // Advance each output's pointer just past the input it served.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the pointer array is tiny control state, not a RAM, so it is
        // reset like any other register.
        if (rst) begin
            for (int o = 0; o < NPORT; o++) ptr_q[o] <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                for (int i = 0; i < NPORT; i++) begin
                    if (gnt[o][i]) ptr_q[o] <= (i == NPORT-1) ? '0 : PW'(i+1);
                end
            end
        end
    end

    // Count simultaneous drops and add them with saturation.
    always_comb begin
        drop_add = '0;
        for (int i = 0; i < NPORT; i++) drop_add = drop_add + {2'b00, illegal[i]};
        drop_sum = {1'b0, drop_cnt_q} + (CW+1)'(drop_add);
    end

    // Saturating drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_sum[CW]) begin
            drop_cnt_q <= '1;
        end else begin
            drop_cnt_q <= drop_sum[CW-1:0];
        end
    end

    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Directed self-checking bench for xbar_rr_arbiter.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_xbar_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  empty_i;
    logic [14:0] address_route_i;
    logic [4:0]  ready_i;
    logic [4:0]  tail_i;
    logic [4:0]  pop_req_o;
    logic [24:0] grant_o;
    logic [7:0]  drop_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    xbar_rr_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .empty_i         (empty_i),
        .address_route_i (address_route_i),
        .ready_i         (ready_i),
        .tail_i          (tail_i),
        .pop_req_o       (pop_req_o),
        .grant_o         (grant_o),
        .drop_cnt_o      (drop_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_in(input int i, input logic [2:0] addr, input logic tail);
        empty_i[i]                 = 1'b0;
        address_route_i[3*i +: 3]  = addr;
        tail_i[i]                  = tail;
    endtask

    task automatic idle_all();
        empty_i         = 5'b11111;
        address_route_i = '0;
        tail_i          = '0;
        ready_i         = 5'b11111;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] gbit(input int o, input int i);
        return 32'(1) << (5*o + i);
    endfunction

    initial begin
        idle_all();
        rst = 1'b0;
        #2;
        // Reset with all inputs actively requesting E: outputs must stay low.
        for (int i = 0; i < 5; i++) set_in(i, 3'd2, 1'b0);
        rst = 1'b1;
        #1;
        check("reset_pop", 32'(pop_req_o), 32'h0);
        check("reset_grant", 32'(grant_o), 32'h0);
        check("reset_drop", 32'(drop_cnt_o), 32'h0);
        next_cycle();
        rst = 1'b0;

        // All five inputs to E: served 0,1,2,3,4,0.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rr_pop_c%0d", c), 32'(pop_req_o), 32'(1) << (c % 5));
            check($sformatf("rr_grant_c%0d", c), 32'(grant_o), gbit(2, c % 5));
            next_cycle();
        end

        // Permutation: every input to a distinct output in one cycle.
        idle_all();
        do_reset();
        set_in(0, 3'd1, 1'b0);
        set_in(1, 3'd0, 1'b0);
        set_in(2, 3'd3, 1'b0);
        set_in(3, 3'd2, 1'b0);
        set_in(4, 3'd4, 1'b0);
        @(negedge clk);
        check("perm_pop", 32'(pop_req_o), 32'h1f);
        check("perm_grant", 32'(grant_o),
              gbit(1, 0) | gbit(0, 1) | gbit(3, 2) | gbit(2, 3) | gbit(4, 4));
        next_cycle();

        // N and W to L with L not ready for three cycles.
        idle_all();
        do_reset();
        set_in(0, 3'd4, 1'b0);
        set_in(3, 3'd4, 1'b0);
        ready_i = 5'b01111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_pop_c%0d", c), 32'(pop_req_o), 32'h0);
            check($sformatf("stall_grant_c%0d", c), 32'(grant_o), 32'h0);
            next_cycle();
        end
        ready_i = 5'b11111;
        @(negedge clk);
        check("stall_rel_pop_n", 32'(pop_req_o), 32'h01);
        check("stall_rel_grant_n", 32'(grant_o), gbit(4, 0));
        next_cycle();
        @(negedge clk);
        check("stall_rel_pop_w", 32'(pop_req_o), 32'h08);
        check("stall_rel_grant_w", 32'(grant_o), gbit(4, 3));
        next_cycle();

        // S with illegal address 6 for 300 cycles: counter saturates at 255.
        idle_all();
        do_reset();
        set_in(1, 3'd6, 1'b0);
        @(negedge clk);
        check("drop_pop_first", 32'(pop_req_o), 32'h02);
        check("drop_grant_first", 32'(grant_o), 32'h0);
        for (int c = 1; c <= 300; c++) begin
            next_cycle();
            if (c == 1 || c == 2 || c == 254 || c == 255 || c == 256 || c == 300)
                check($sformatf("drop_cnt_e%0d", c), 32'(drop_cnt_o), (c > 255) ? 32'd255 : 32'(c));
        end
        @(negedge clk);
        check("drop_pop_last", 32'(pop_req_o), 32'h02);
        check("drop_grant_last", 32'(grant_o), 32'h0);

        // Five simultaneous illegal heads add five per cycle.
        idle_all();
        do_reset();
        set_in(0, 3'd5, 1'b0);
        set_in(1, 3'd6, 1'b0);
        set_in(2, 3'd7, 1'b0);
        set_in(3, 3'd5, 1'b0);
        set_in(4, 3'd7, 1'b0);
        @(negedge clk);
        check("multi_drop_pop", 32'(pop_req_o), 32'h1f);
        check("multi_drop_grant", 32'(grant_o), 32'h0);
        next_cycle();
        check("multi_drop_cnt1", 32'(drop_cnt_o), 32'd5);
        next_cycle();
        check("multi_drop_cnt2", 32'(drop_cnt_o), 32'd10);

        // Asynchronous reset in the middle of traffic.
        idle_all();
        do_reset();
        set_in(0, 3'd2, 1'b0);
        set_in(1, 3'd6, 1'b0);
        set_in(2, 3'd2, 1'b0);
        set_in(3, 3'd2, 1'b0);
        set_in(4, 3'd2, 1'b0);
        @(negedge clk);
        check("mid_pop_c0", 32'(pop_req_o), 32'h03);
        check("mid_grant_c0", 32'(grant_o), gbit(2, 0));
        next_cycle();
        @(negedge clk);
        check("mid_pop_c1", 32'(pop_req_o), 32'h06);
        check("mid_grant_c1", 32'(grant_o), gbit(2, 2));
        next_cycle();
        check("mid_drop_before", 32'(drop_cnt_o), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_pop", 32'(pop_req_o), 32'h0);
        check("async_grant", 32'(grant_o), 32'h0);
        check("async_drop", 32'(drop_cnt_o), 32'h0);
        next_cycle();
        rst = 1'b0;
        set_in(1, 3'd2, 1'b0);
        @(negedge clk);
        check("post_rst_grant", 32'(grant_o), gbit(2, 0));
        check("post_rst_drop", 32'(drop_cnt_o), 32'h0);
        next_cycle();

`ifdef XBAR_ARB_PKT_LOCK_EN
        // W sends a 3-flit packet to N while L also wants N.
        idle_all();
        do_reset();
        set_in(3, 3'd0, 1'b0);
        set_in(4, 3'd0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            tail_i[3] = (f == 2);
            @(negedge clk);
            check($sformatf("lock_pop_f%0d", f), 32'(pop_req_o), 32'h08);
            check($sformatf("lock_grant_f%0d", f), 32'(grant_o), gbit(0, 3));
            next_cycle();
        end
        empty_i[3] = 1'b1;
        @(negedge clk);
        check("lock_after_pop", 32'(pop_req_o), 32'h10);
        check("lock_after_grant", 32'(grant_o), gbit(0, 4));
        next_cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
